i4001_rom_arbiter: RTL and testbench
====================================

# i4001_rom_arbiter

Arbitrates the single port of the shared `i4001_rom` block RAM between two requesters. The first is the CPU fetch path: the wired-OR `rom_addr` bus driven by all `i4001` chips. The second is a host loader/debug port that reads and writes ROM contents at run time. The block sits between the `i4001` array and `i4001_rom`. Fetch always has priority, and loader accesses use only idle RAM cycles.

## Interface
Parameters:
- `ADDR_W`, 12: ROM address width. Holds the 4-bit chip number plus an 8-bit offset.
- `DATA_W`, 8: ROM word width.
- `GUARD`, 2: number of idle cycles required after `fetch_valid` falls before the loader may be granted. Legal range is 0–15.

Ports:
- `sysclk` in 1: the only clock.
- `poc_n` in 1: reset, asynchronous assert, active-low.
- `fetch_valid` in 1: a chip is driving `fetch_addr`, i.e. the OR of every chip's `extbusdrive`.
- `fetch_addr` in `ADDR_W`: the wired-OR `rom_addr` bus.
- `fetch_data` out `DATA_W`: registered ROM word returned to the chips. Holds its value between fetches.
- `ld_req` in 1: loader request. It is a level signal and is held until `ld_ack`.
- `ld_we` in 1: 1 means write, 0 means read. Must be stable while `ld_req` is high.
- `ld_addr` in `ADDR_W`: loader address. Must be stable while `ld_req` is high.
- `ld_wdata` in `DATA_W`: loader write data. Must be stable while `ld_req` is high.
- `ld_ack` out 1: one-cycle completion pulse.
- `ld_rdata` out `DATA_W`: read data. Valid in the `ld_ack` cycle and held afterwards.
- `ram_en` out 1: RAM port enable.
- `ram_we` out 1: RAM port write enable.
- `ram_addr` out `ADDR_W`: RAM port address.
- `ram_wdata` out `DATA_W`: RAM port write data.
- `ram_rdata` in `DATA_W`: synchronous RAM read data, one cycle after `ram_en`.
- `stat_fetch` out 16: number of fetch-granted cycles, saturating.
- `stat_ld_wait` out 16: number of cycles with `ld_req` high but not granted, saturating.

## Operation
Grant is decided combinationally each cycle:
- FETCH if `fetch_valid` is high.
- Otherwise LOADER if the loader FSM is in L_PEND and the guard counter is 0.
- Otherwise NONE.

RAM port outputs:
- FETCH: `ram_en`=1, `ram_we`=0, `ram_addr`=`fetch_addr`.
- LOADER: `ram_en`=1, `ram_we`=`ld_we`, `ram_addr`=`ld_addr`, `ram_wdata`=`ld_wdata`.
- NONE: `ram_en`=0 and `ram_we`=0. `ram_addr` and `ram_wdata` are don't-care, and the bench treats them as 0.

The grant is registered as `gnt_q`, which has three values: NONE, FETCH and LOADER. In the following cycle:
- `gnt_q`=FETCH: `fetch_data` <= `ram_rdata`.
- `gnt_q`=LOADER: `ld_rdata` <= `ram_rdata` if the access was a read; `ld_rdata` is unchanged on a write. `ld_ack` is pulsed high.

Guard counter:
- Loaded with `GUARD` in every cycle that `fetch_valid` is high.
- Otherwise decremented toward 0.
- Reset value is 0.

Loader FSM:
- L_IDLE: goes to L_PEND when `ld_req` is high.
- L_PEND: goes to L_BUSY on a LOADER grant.
- L_BUSY: pulses `ld_ack`, then goes to L_DONE.
- L_DONE: ignores `ld_req` for this one cycle, then goes to L_IDLE. This prevents a held `ld_req` from being re-issued.

Consequences:
- Back-to-back loader ops take at least 4 cycles each.
- A loader op in flight (L_BUSY) is never preempted, because it has already been issued.
- `fetch_valid` rising during L_PEND simply defers the grant.

Boundary behaviour:
- Write followed by fetch of the same address: the fetch returns the new data. RAM read-after-write ordering is cycle-exact because the port is single and sequential.
- `ld_req` dropping while in L_PEND is illegal. Behaviour is undefined, but the FSM must not hang.
- Address wrap-around: none. The full `ADDR_W` is passed through unmodified.

## Timing
- Fetch latency is 2 cycles: `fetch_addr` is sampled in cycle N, RAM returns data in N+1, and `fetch_data` is updated at the edge ending N+1.
- Loader latency is 3 cycles minimum from `ld_req` rising to `ld_ack` high, with no fetch traffic and `GUARD`=0.
- When `fetch_valid` falls at cycle N, the loader grant becomes possible at cycle N+`GUARD`.
- Reset values while `poc_n`=0:
  - `fetch_data`=0, `ld_ack`=0, `ld_rdata`=0.
  - `ram_en`=0, `ram_we`=0.
  - Both stat counters = 0.
  - FSM = L_IDLE, `gnt_q`=NONE, guard counter = 0.
- Reset asserted mid-operation aborts the pending or in-flight loader op: no ack is issued. A RAM write in the same cycle as reset assertion is not guaranteed to have been performed.

## Configuration
- `I4001_ROM_ARB_STATS_EN` defined:
  - `stat_fetch` increments on each FETCH grant.
  - `stat_ld_wait` increments on each cycle with the FSM in L_PEND and no LOADER grant.
  - Both counters saturate at 16'hFFFF.
- Macro undefined: both counter registers are omitted and the stat outputs are tied to 0. The ports remain present in both builds.

## Test plan
- Reset release with no traffic: every output is 0 and `ram_en` stays 0 for 20 cycles.
- Preload RAM 0x1A5 = 8'hC3, then `fetch_valid`=1 with `fetch_addr`=12'h1A5: `fetch_data`=8'hC3 two cycles later and held after `fetch_valid` drops.
- Loader write of 8'h5E to 12'h0F0 with no fetch traffic: `ld_ack` pulses exactly once, 3 cycles after `ld_req`. A following loader read of 12'h0F0 returns `ld_rdata`=8'h5E. A later fetch of 12'h0F0 returns 8'h5E.
- Loader request held during continuous `fetch_valid` for 50 cycles with `GUARD`=2: no LOADER grant occurs. The grant occurs exactly 2 cycles after `fetch_valid` falls, and with the macro defined `stat_ld_wait` ≥ 50.
- `fetch_valid` rises in the same cycle the loader is in L_BUSY: the loader acks normally and the fetch data arrives one cycle later, uncorrupted.
- `poc_n` pulsed low while in L_PEND: no `ld_ack` is issued, the FSM returns to L_IDLE, and a fresh request then completes normally.

Source files
------------

// File: rtl/i4001_rom_arbiter.sv
// i4001_rom_arbiter
// -----------------
// Shares the single port of the i4001_rom block RAM between the CPU fetch
// path (wired-OR rom_addr bus of the i4001 array) and a host loader/debug
// port. Fetch always wins; loader accesses only use idle RAM cycles, and
// only after GUARD idle cycles have passed since fetch_valid was last high.
//
// Ports:
//   sysclk, poc_n          clock, asynchronous active-low reset
//   fetch_valid/addr/data  CPU fetch request and registered returned word
//   ld_req/we/addr/wdata   loader request (level, held until ld_ack)
//   ld_ack, ld_rdata       one-cycle completion pulse, read data (held)
//   ram_en/we/addr/wdata   RAM port drive
//   ram_rdata              synchronous RAM read data (1 cycle after ram_en)
//   stat_fetch, stat_ld_wait  saturating statistics counters
//
// Optional feature: define I4001_ROM_ARB_STATS_EN to build the statistics
// counters; otherwise the stat outputs are tied to 0.

module i4001_rom_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int GUARD  = 2
) (
    input  logic              sysclk,
    input  logic              poc_n,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [15:0]       stat_fetch,
    output logic [15:0]       stat_ld_wait
);

    typedef enum logic [1:0] {G_NONE, G_FETCH, G_LOADER} gnt_t;
    typedef enum logic [1:0] {L_IDLE, L_PEND, L_BUSY, L_DONE} ld_state_t;

    localparam logic [3:0] GUARD_LD = 4'(GUARD);

    gnt_t       grant;
    gnt_t       gnt_q;
    ld_state_t  state;
    ld_state_t  state_nxt;
    logic [3:0] guard_cnt;
    logic       ld_we_q;

    // Combinational grant. Held at NONE during reset so the RAM port is quiet.
    always_comb begin
        grant = G_NONE;
        if (!poc_n)
            grant = G_NONE;
        else if (fetch_valid)
            grant = G_FETCH;
        else if (state == L_PEND && guard_cnt == 4'd0)
            grant = G_LOADER;
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (grant)
            G_FETCH: begin
                ram_en   = 1'b1;
                ram_addr = fetch_addr;
            end
            G_LOADER: begin
                ram_en    = 1'b1;
                ram_we    = ld_we;
                ram_addr  = ld_addr;
                ram_wdata = ld_wdata;
            end
            default: ;
        endcase
    end

    // The read/write flag is captured with the grant so the return cycle
    // knows whether ram_rdata belongs to the loader.
    always_ff @(posedge sysclk or negedge poc_n) begin
        if (!poc_n) begin
            gnt_q      <= G_NONE;
            ld_we_q    <= 1'b0;
            guard_cnt  <= 4'd0;
            state      <= L_IDLE;
            fetch_data <= '0;
            ld_rdata   <= '0;
            ld_ack     <= 1'b0;
        end else begin
            gnt_q   <= grant;
            ld_we_q <= ld_we;
            state   <= state_nxt;
            if (fetch_valid)
                guard_cnt <= GUARD_LD;
            else if (guard_cnt != 4'd0)
                guard_cnt <= guard_cnt - 4'd1;
            if (gnt_q == G_FETCH)
                fetch_data <= ram_rdata;
            if (gnt_q == G_LOADER && !ld_we_q)
                ld_rdata <= ram_rdata;
            ld_ack <= (gnt_q == G_LOADER);
        end
    end

    // L_DONE swallows one cycle so a still-held ld_req is not re-issued.
    // A request dropped while pending returns to idle rather than hanging.
    always_comb begin
        state_nxt = state;
        case (state)
            L_IDLE: if (ld_req) state_nxt = L_PEND;
            L_PEND: begin
                if (grant == G_LOADER)
                    state_nxt = L_BUSY;
                else if (!ld_req)
                    state_nxt = L_IDLE;
            end
            L_BUSY: state_nxt = L_DONE;
            L_DONE: state_nxt = L_IDLE;
            default: state_nxt = L_IDLE;
        endcase
    end

`ifdef I4001_ROM_ARB_STATS_EN
    logic [15:0] fetch_cnt;
    logic [15:0] wait_cnt;

    always_ff @(posedge sysclk or negedge poc_n) begin
        if (!poc_n) begin
            fetch_cnt <= 16'd0;
            wait_cnt  <= 16'd0;
        end else begin
            if (grant == G_FETCH && fetch_cnt != 16'hFFFF)
                fetch_cnt <= fetch_cnt + 16'd1;
            if (state == L_PEND && grant != G_LOADER && wait_cnt != 16'hFFFF)
                wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign stat_fetch   = fetch_cnt;
    assign stat_ld_wait = wait_cnt;
`else
    assign stat_fetch   = 16'd0;
    assign stat_ld_wait = 16'd0;
`endif

endmodule

// File: tb/tb_i4001_rom_arbiter.sv
// tb_i4001_rom_arbiter
// --------------------
// Directed bench for i4001_rom_arbiter with a behavioural synchronous RAM.
// A cycle-by-cycle vector table covers fetch, loader write/read and a fetch
// landing while the loader is busy; hand-written sequences cover the long
// fetch-blocked loader request and reset during a pending request.

module tb_i4001_rom_arbiter;

    logic        sysclk = 1'b0;
    logic        poc_n;
    logic        fetch_valid;
    logic [11:0] fetch_addr;
    logic [7:0]  fetch_data;
    logic        ld_req;
    logic        ld_we;
    logic [11:0] ld_addr;
    logic [7:0]  ld_wdata;
    logic        ld_ack;
    logic [7:0]  ld_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [15:0] stat_fetch;
    logic [15:0] stat_ld_wait;

    i4001_rom_arbiter #(.ADDR_W(12), .DATA_W(8), .GUARD(2)) dut (
        .sysclk(sysclk), .poc_n(poc_n),
        .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .stat_fetch(stat_fetch), .stat_ld_wait(stat_ld_wait)
    );

    always #5 sysclk = ~sysclk;

    // Behavioural single-port synchronous RAM, preloaded while init_mem is high.
    logic [7:0] mem [0:4095];
    logic       init_mem;

    always @(posedge sysclk) begin
        if (init_mem) begin
            mem[12'h1A5] <= 8'hC3;
            mem[12'hFFF] <= 8'h99;
            mem[12'h0F0] <= 8'h00;
            mem[12'h333] <= 8'h00;
            mem[12'h444] <= 8'h00;
        end else if (ram_en) begin
            if (ram_we)
                mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    typedef struct {
        logic        fv;
        logic [11:0] fa;
        logic        req;
        logic        we;
        logic [11:0] la;
        logic [7:0]  wd;
        logic        en;
        logic        rwe;
        logic [11:0] raddr;
        logic [7:0]  rwdata;
        logic [7:0]  fd;
        logic        ack;
        logic [7:0]  rd;
    } vec_t;

    vec_t vecs [22];
    int   checks = 0;
    int   errors = 0;
    int   fetch_cycles = 0;

    function automatic vec_t mk(
        input logic fv, input logic [11:0] fa, input logic req, input logic we,
        input logic [11:0] la, input logic [7:0] wd, input logic en, input logic rwe,
        input logic [11:0] raddr, input logic [7:0] rwdata, input logic [7:0] fd,
        input logic ack, input logic [7:0] rd);
        vec_t v;
        v.fv = fv; v.fa = fa; v.req = req; v.we = we; v.la = la; v.wd = wd;
        v.en = en; v.rwe = rwe; v.raddr = raddr; v.rwdata = rwdata;
        v.fd = fd; v.ack = ack; v.rd = rd;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic fv, input logic [11:0] fa, input logic req,
                                  input logic we, input logic [11:0] la, input logic [7:0] wd);
        fetch_valid = fv;
        fetch_addr  = fa;
        ld_req      = req;
        ld_we       = we;
        ld_addr     = la;
        ld_wdata    = wd;
        if (fv && poc_n)
            fetch_cycles++;
    endtask

    task automatic next_cycle();
        @(posedge sysclk);
        #1;
    endtask

    // Issues one loader op from idle and checks ack latency, single pulse and data.
    task automatic loader_op(input logic we, input logic [11:0] la, input logic [7:0] wd,
                             input logic [7:0] exp_rd, input string tag);
        int lat;
        lat = -1;
        apply_stimulus(1'b0, 12'h000, 1'b1, we, la, wd);
        for (int k = 0; k < 20; k++) begin
            @(negedge sysclk);
            if (ld_ack) begin
                lat = k;
                break;
            end
            next_cycle();
        end
        check_output({tag, " ack_latency"}, 32'(lat), 32'd3);
        if (!we)
            check_output({tag, " ld_rdata"}, 32'(ld_rdata), 32'(exp_rd));
        next_cycle();
        apply_stimulus(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00);
        @(negedge sysclk);
        check_output({tag, " ack_single"}, 32'(ld_ack), 32'd0);
        next_cycle();
    endtask

    initial begin
        vecs[0]  = mk(1, 12'h1A5, 0, 0, 12'h000, 8'h00, 1, 0, 12'h1A5, 8'h00, 8'h00, 0, 8'h00);
        vecs[1]  = mk(0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 8'h00, 0, 8'h00);
        vecs[2]  = mk(0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 8'hC3, 0, 8'h00);
        vecs[3]  = mk(0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 8'hC3, 0, 8'h00);
        vecs[4]  = mk(0, 12'h000, 1, 1, 12'h0F0, 8'h5E, 0, 0, 12'h000, 8'h00, 8'hC3, 0, 8'h00);
        vecs[5]  = mk(0, 12'h000, 1, 1, 12'h0F0, 8'h5E, 1, 1, 12'h0F0, 8'h5E, 8'hC3, 0, 8'h00);
        vecs[6]  = mk(0, 12'h000, 1, 1, 12'h0F0, 8'h5E, 0, 0, 12'h000, 8'h00, 8'hC3, 0, 8'h00);
        vecs[7]  = mk(0, 12'h000, 1, 1, 12'h0F0, 8'h5E, 0, 0, 12'h000, 8'h00, 8'hC3, 1, 8'h00);
        vecs[8]  = mk(0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 8'hC3, 0, 8'h00);
        vecs[9]  = mk(0, 12'h000, 1, 0, 12'h0F0, 8'h00, 0, 0, 12'h000, 8'h00, 8'hC3, 0, 8'h00);
        vecs[10] = mk(0, 12'h000, 1, 0, 12'h0F0, 8'h00, 1, 0, 12'h0F0, 8'h00, 8'hC3, 0, 8'h00);
        vecs[11] = mk(0, 12'h000, 1, 0, 12'h0F0, 8'h00, 0, 0, 12'h000, 8'h00, 8'hC3, 0, 8'h00);
        vecs[12] = mk(0, 12'h000, 1, 0, 12'h0F0, 8'h00, 0, 0, 12'h000, 8'h00, 8'hC3, 1, 8'h5E);
        vecs[13] = mk(0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 8'hC3, 0, 8'h5E);
        vecs[14] = mk(1, 12'h0F0, 0, 0, 12'h000, 8'h00, 1, 0, 12'h0F0, 8'h00, 8'hC3, 0, 8'h5E);
        vecs[15] = mk(0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 8'hC3, 0, 8'h5E);
        vecs[16] = mk(0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 8'h5E, 0, 8'h5E);
        vecs[17] = mk(0, 12'h000, 1, 0, 12'h1A5, 8'h00, 0, 0, 12'h000, 8'h00, 8'h5E, 0, 8'h5E);
        vecs[18] = mk(0, 12'h000, 1, 0, 12'h1A5, 8'h00, 1, 0, 12'h1A5, 8'h00, 8'h5E, 0, 8'h5E);
        vecs[19] = mk(1, 12'hFFF, 1, 0, 12'h1A5, 8'h00, 1, 0, 12'hFFF, 8'h00, 8'h5E, 0, 8'h5E);
        vecs[20] = mk(0, 12'h000, 1, 0, 12'h1A5, 8'h00, 0, 0, 12'h000, 8'h00, 8'h5E, 1, 8'hC3);
        vecs[21] = mk(0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 8'h99, 0, 8'hC3);

        // Reset with RAM preload.
        poc_n    = 1'b0;
        init_mem = 1'b1;
        apply_stimulus(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00);
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        check_output("rst fetch_data", 32'(fetch_data), 32'd0);
        check_output("rst ld_ack", 32'(ld_ack), 32'd0);
        check_output("rst ld_rdata", 32'(ld_rdata), 32'd0);
        check_output("rst ram_en", 32'(ram_en), 32'd0);
        check_output("rst ram_we", 32'(ram_we), 32'd0);
        check_output("rst stat_fetch", 32'(stat_fetch), 32'd0);
        check_output("rst stat_ld_wait", 32'(stat_ld_wait), 32'd0);
        init_mem = 1'b0;
        next_cycle();
        poc_n = 1'b1;

        // Twenty quiet cycles after reset release.
        for (int i = 0; i < 20; i++) begin
            @(negedge sysclk);
            check_output($sformatf("idle%0d ram_en", i), 32'(ram_en), 32'd0);
            check_output($sformatf("idle%0d outs", i),
                         32'({fetch_data, ld_rdata, ld_ack, ram_we}), 32'd0);
            next_cycle();
        end

        // Cycle-by-cycle vector table.
        for (int i = 0; i < 22; i++) begin
            apply_stimulus(vecs[i].fv, vecs[i].fa, vecs[i].req, vecs[i].we, vecs[i].la, vecs[i].wd);
            @(negedge sysclk);
            check_output($sformatf("v%0d ram_en", i), 32'(ram_en), 32'(vecs[i].en));
            check_output($sformatf("v%0d ram_we", i), 32'(ram_we), 32'(vecs[i].rwe));
            check_output($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(vecs[i].raddr));
            if (vecs[i].rwe)
                check_output($sformatf("v%0d ram_wdata", i), 32'(ram_wdata), 32'(vecs[i].rwdata));
            check_output($sformatf("v%0d fetch_data", i), 32'(fetch_data), 32'(vecs[i].fd));
            check_output($sformatf("v%0d ld_ack", i), 32'(ld_ack), 32'(vecs[i].ack));
            check_output($sformatf("v%0d ld_rdata", i), 32'(ld_rdata), 32'(vecs[i].rd));
            next_cycle();
        end

        // Loader write held off by 50 cycles of continuous fetch traffic.
        apply_stimulus(1'b1, 12'h1A5, 1'b1, 1'b1, 12'h333, 8'h77);
        for (int i = 0; i < 50; i++) begin
            @(negedge sysclk);
            check_output($sformatf("block%0d ram", i), 32'({ram_en, ram_we, ram_addr}),
                         32'({1'b1, 1'b0, 12'h1A5}));
            next_cycle();
            if (i < 49)
                apply_stimulus(1'b1, 12'h1A5, 1'b1, 1'b1, 12'h333, 8'h77);
        end
        apply_stimulus(1'b0, 12'h000, 1'b1, 1'b1, 12'h333, 8'h77);
        @(negedge sysclk);
        check_output("guard N ram_en", 32'(ram_en), 32'd0);
        next_cycle();
        @(negedge sysclk);
        check_output("guard N+1 ram_en", 32'(ram_en), 32'd0);
        next_cycle();
        @(negedge sysclk);
        check_output("guard N+2 ram", 32'({ram_en, ram_we, ram_addr, ram_wdata}),
                     32'({1'b1, 1'b1, 12'h333, 8'h77}));
`ifdef I4001_ROM_ARB_STATS_EN
        check_output("stat_ld_wait>=50", 32'(stat_ld_wait >= 16'd50), 32'd1);
`else
        check_output("stat_ld_wait off", 32'(stat_ld_wait), 32'd0);
`endif
        next_cycle();
        @(negedge sysclk);
        check_output("guard busy ack", 32'(ld_ack), 32'd0);
        next_cycle();
        @(negedge sysclk);
        check_output("guard done ack", 32'(ld_ack), 32'd1);
        check_output("guard mem write", 32'(mem[12'h333]), 32'h77);
`ifdef I4001_ROM_ARB_STATS_EN
        check_output("stat_fetch", 32'(stat_fetch), 32'(fetch_cycles));
`else
        check_output("stat_fetch off", 32'(stat_fetch), 32'd0);
`endif
        next_cycle();
        apply_stimulus(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00);
        next_cycle();

        // Reset while a write request is pending behind fetch traffic.
        apply_stimulus(1'b1, 12'h1A5, 1'b1, 1'b1, 12'h444, 8'h11);
        next_cycle();
        apply_stimulus(1'b1, 12'h1A5, 1'b1, 1'b1, 12'h444, 8'h11);
        @(negedge sysclk);
        check_output("pend ram_we", 32'(ram_we), 32'd0);
        next_cycle();
        poc_n = 1'b0;
        apply_stimulus(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00);
        fetch_cycles = 0;
        @(negedge sysclk);
        check_output("mid-rst outs", 32'({fetch_data, ld_rdata, ld_ack, ram_en, ram_we}), 32'd0);
        next_cycle();
        poc_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge sysclk);
            check_output($sformatf("post-rst%0d ack/en", i), 32'({ld_ack, ram_en}), 32'd0);
            next_cycle();
        end
        check_output("aborted write", 32'(mem[12'h444]), 32'h00);

        // Fresh requests after the abort complete normally.
        loader_op(1'b1, 12'h444, 8'hA6, 8'h00, "fresh wr");
        loader_op(1'b0, 12'h444, 8'h00, 8'hA6, "fresh rd");
        loader_op(1'b0, 12'h333, 8'h00, 8'h77, "rd 333");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench cannot hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
